// File: rtl/seg_scan_driver_if.sv
// Digit-bus and display-pin bundle for seg_scan_driver.
// master = upstream digit source, slave = the scan driver itself.
interface seg_scan_driver_if;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [7:0]  seg;
  logic [3:0]  dig_sel;
  logic        frame_start;

  modport master (
    output digits_in,
    output dp_in,
    input  seg,
    input  dig_sel,
    input  frame_start
  );

  modport slave (
    input  digits_in,
    input  dp_in,
    output seg,
    output dig_sel,
    output frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame snapshot and
// anti-ghosting guard blanking. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(BLANK_CYC);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_GUARD,
    ST_DRIVE
  } state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [1:0]    idx;
  logic [15:0]   shadow_digits;
  logic [3:0]    shadow_dp;

  logic        capture;
  logic        slot_end;
  logic [15:0] digits_next;
  logic [3:0]  dp_next;
  logic [3:0]  blank_next;
  logic [3:0]  cur_nib;
  logic [6:0]  cur_glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // The first edge out of reset counts as the digit-0 boundary, as does every
  // later wrap into slot 0.
  assign capture  = (state == ST_RESET) || ((pcnt == '0) && (idx == 2'd0));
  assign slot_end = (pcnt == PCNT_LAST);

  // seg is loaded on the capture edge itself, so decode from the value about
  // to enter the shadow rather than the stale shadow.
  always_comb begin
    digits_next = shadow_digits;
    dp_next     = shadow_dp;
    if (capture) begin
      digits_next = bus.digits_in;
      dp_next     = bus.dp_in;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank_mask;

  // A digit is blanked only if it and every digit above it are zero.
  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m;
    m    = 4'b0000;
    m[3] = (d[15:12] == 4'h0);
    m[2] = m[3] && (d[11:8] == 4'h0);
    m[1] = m[2] && (d[7:4] == 4'h0);
    return m;
  endfunction

  always_comb begin
    blank_next = blank_mask;
    if (capture) begin
      blank_next = lz_mask(bus.digits_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_mask <= 4'b0000;
    end else begin
      blank_mask <= blank_next;
    end
  end
`else
  always_comb begin
    blank_next = 4'b0000;
  end
`endif

  always_comb begin
    cur_nib   = digits_next[{idx, 2'b00} +: 4];
    cur_glyph = hex_glyph(cur_nib);
    if (blank_next[idx]) begin
      cur_glyph = 7'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_RESET;
      pcnt            <= '0;
      idx             <= 2'd0;
      shadow_digits   <= 16'h0000;
      shadow_dp       <= 4'b0000;
      bus.seg         <= 8'h00;
      bus.dig_sel     <= 4'b1111;
      bus.frame_start <= 1'b0;
    end else begin
      pcnt            <= slot_end ? '0 : pcnt + 1'b1;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      shadow_digits   <= digits_next;
      shadow_dp       <= dp_next;
      bus.frame_start <= capture;
      bus.seg         <= {dp_next[idx], cur_glyph};
      // Select changes on the same edge as seg, and the guard always opens a
      // slot, so the new pattern never meets the previous digit's enable.
      if (pcnt < GUARD_END) begin
        state       <= ST_GUARD;
        bus.dig_sel <= 4'b1111;
      end else begin
        state       <= ST_DRIVE;
        bus.dig_sel <= ~(4'b0001 << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed + randomized bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYC=2),
// checked against a frame/slot arithmetic model of the display.
module tb_seg_scan_driver;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .SCAN_DIV (SD),
    .BLANK_CYC(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;
  int cyc         = 0;
  int since       = 0;
  int last_fs     = -1;

  logic [15:0] cur_digits = 16'h0000;
  logic [3:0]  cur_dp     = 4'b0000;
  logic [15:0] snap_d     = 16'h0000;
  logic [3:0]  snap_dp    = 4'b0000;

  byte unsigned glyph_tab [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] dp);
    cur_digits    = d;
    cur_dp        = dp;
    bus.digits_in = d;
    bus.dp_in     = dp;
  endtask

  // Advance one clock edge, predict the outputs that edge produces, compare.
  task automatic tick();
    logic [7:0] exp_seg;
    logic [3:0] exp_sel;
    logic       exp_fs;
    logic [3:0] nib;
    logic [7:0] g;
    logic       legal;
    int         slot;
    int         pos;
    int         msd;
    @(posedge clk);
    if (rst) begin
      exp_seg = 8'h00;
      exp_sel = 4'b1111;
      exp_fs  = 1'b0;
      since   = 0;
    end else begin
      if (since % FRAME == 0) begin
        snap_d  = cur_digits;
        snap_dp = cur_dp;
      end
      slot    = (since % FRAME) / SD;
      pos     = since % SD;
      nib     = snap_d[slot*4 +: 4];
      g       = glyph_tab[nib];
      exp_seg = {snap_dp[slot], g[6:0]};
`ifdef LEADING_ZERO_BLANK_EN
      msd = 0;
      for (int k = 0; k < 4; k++) begin
        if (snap_d[k*4 +: 4] != 4'h0) msd = k;
      end
      if (slot > msd) exp_seg[6:0] = 7'h00;
`else
      msd = 0;
`endif
      exp_sel = 4'b1111;
      if (pos >= BC) exp_sel[slot] = 1'b0;
      exp_fs = (since % FRAME == 0);
      since++;
    end
    #1;
    legal = (bus.dig_sel inside {4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111});
    check_output("seg", 32'(bus.seg), 32'(exp_seg));
    check_output("dig_sel", 32'(bus.dig_sel), 32'(exp_sel));
    check_output("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    check_output("dig_sel_legal", 32'(legal), 32'd1);
    cyc++;
  endtask

  initial begin
    $display("[TB] seg_scan_driver bench start");
    apply_stimulus(16'h0000, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("[TB] release with 1234, swap to ABCD mid slot 2");
    apply_stimulus(16'h1234, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    apply_stimulus(16'hABCD, 4'b0000);
    for (int i = 0; i < 46; i++) tick();

    $display("[TB] zero digits with dp 0101");
    apply_stimulus(16'h0000, 4'b0101);
    for (int i = 0; i < 64; i++) tick();

    $display("[TB] reset pulse at pcnt 5 of slot 2");
    apply_stimulus(16'h1234, 4'b0000);
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply_stimulus(16'h5E09, 4'b1000);
    for (int i = 0; i < 40; i++) tick();

    $display("[TB] random inputs");
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(16'($urandom), 4'($urandom));
      tick();
      if (bus.frame_start === 1'b1) begin
        if (last_fs >= 0) check_output("fs_period", 32'(cyc - last_fs), 32'(FRAME));
        last_fs = cyc;
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
